// File: rtl/apb_pkg.sv
// apb_pkg
// Shared definitions for the APB register subordinate:
//   apb_sub_state_t - transfer FSM states
//   PROT_PRIV_BIT   - prot bit that marks a privileged access
//   strb_mask()     - expands up to 8 byte strobes into a 64-bit bit mask
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } apb_sub_state_t;

    localparam int PROT_PRIV_BIT = 0;

    // Callers with narrower buses zero-pad the strobes and keep the low bits.
    function automatic logic [63:0] strb_mask(input logic [7:0] strb);
        logic [63:0] mask;
        for (int i = 0; i < 8; i++) begin
            mask[i*8 +: 8] = {8{strb[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/apb_reg_subordinate_if.sv
// apb_reg_subordinate_if
// APB signal set between a requester (master modport) and this
// register subordinate (slave modport).
//   sel, enable, addr, write, wData, strb, prot : requester -> subordinate
//   ready, rData, subError                      : subordinate -> requester
interface apb_reg_subordinate_if #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
);

    logic                   sel;
    logic                   enable;
    logic [AddrWidth-1:0]   addr;
    logic                   write;
    logic [DataWidth-1:0]   wData;
    logic [DataWidth/8-1:0] strb;
    logic [2:0]             prot;
    logic                   ready;
    logic [DataWidth-1:0]   rData;
    logic                   subError;

    modport master (
        output sel, enable, addr, write, wData, strb, prot,
        input  ready, rData, subError
    );

    modport slave (
        input  sel, enable, addr, write, wData, strb, prot,
        output ready, rData, subError
    );

endinterface

// File: rtl/apb_reg_bank.sv
// apb_reg_bank
// Register storage: RegNum words of DataWidth bits, cleared by reset.
//   clk, nReset : clock and asynchronous active-low reset
//   wrEn        : commit a masked write this edge
//   wrIdx       : register index to write
//   wrMask      : bit mask, 1 = take the bit from wrData
//   wrData      : write data
//   rdIdx       : register index to read (asynchronous)
//   rdData      : current contents of register rdIdx
module apb_reg_bank #(
    parameter int DataWidth = 32,
    parameter int RegNum    = 8,
    parameter int IdxW      = 3
) (
    input  logic                 clk,
    input  logic                 nReset,
    input  logic                 wrEn,
    input  logic [IdxW-1:0]      wrIdx,
    input  logic [DataWidth-1:0] wrMask,
    input  logic [DataWidth-1:0] wrData,
    input  logic [IdxW-1:0]      rdIdx,
    output logic [DataWidth-1:0] rdData
);

    logic [DataWidth-1:0] regs [RegNum];

    // Masked read-modify-write keeps unstrobed byte lanes untouched.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < RegNum; i++) begin
                regs[i] <= '0;
            end
        end else if (wrEn) begin
            regs[wrIdx] <= (regs[wrIdx] & ~wrMask) | (wrData & wrMask);
        end
    end

    assign rdData = regs[rdIdx];

endmodule

// File: rtl/apb_reg_subordinate.sv
// apb_reg_subordinate
// APB completer in front of a bank of RegNum read/write registers.
// Every transfer takes 2+WaitStates cycles; ready, rData and subError are
// all registered.
//   clk    : clock
//   nReset : asynchronous active-low reset
//   bus    : APB signal set (slave modport)
module apb_reg_subordinate
    import apb_pkg::*;
#(
    parameter int AddrWidth  = 32,
    parameter int DataWidth  = 32,
    parameter int RegNum     = 8,
    parameter int WaitStates = 1
) (
    input  logic                  clk,
    input  logic                  nReset,
    apb_reg_subordinate_if.slave  bus
);

    localparam int         StrbWidth = DataWidth / 8;
    localparam int         AlignBits = $clog2(StrbWidth);
    localparam int         IdxBits   = $clog2(RegNum);
    localparam int         IdxW      = (IdxBits == 0) ? 1 : IdxBits;
    localparam logic [3:0] WaitLoad  = 4'(WaitStates);

    apb_sub_state_t       state, stateNext;
    logic [3:0]           cnt, cntNext;
    logic                 latch, enterDone;

    logic [7:0]           strb8;
    logic [63:0]          mask64;
    logic [DataWidth-1:0] maskIn;
    logic [IdxW-1:0]      idxIn;
    logic                 errIn;

    logic [IdxW-1:0]      idxL;
    logic                 writeL;
    logic [DataWidth-1:0] wDataL, maskL;
    logic                 errL;

    logic [IdxW-1:0]      txIdx;
    logic                 txWrite, txErr;
    logic [DataWidth-1:0] txData, txMask;

    logic [DataWidth-1:0] bankRData;
    logic                 bankWrEn;

    logic                 readyQ, subErrorQ;
    logic [DataWidth-1:0] rDataQ;

    // Decode of the setup-phase bus: register index, byte mask and the
    // error verdict that travels with the transfer until ready.
    always_comb begin
        strb8                = '0;
        strb8[StrbWidth-1:0] = bus.strb;
        mask64               = strb_mask(strb8);
        maskIn               = mask64[DataWidth-1:0];
        idxIn                = (RegNum > 1) ? IdxW'(bus.addr >> AlignBits) : '0;
        errIn                = 1'b0;
        if (bus.addr[AlignBits-1:0] != '0) begin
            errIn = 1'b1;
        end
        if ((bus.addr >> (AlignBits + IdxBits)) != '0) begin
            errIn = 1'b1;
        end
        if (!bus.write && bus.strb != '0) begin
            errIn = 1'b1;
        end
        if (bus.write && idxIn == '0 && !bus.prot[PROT_PRIV_BIT]) begin
            errIn = 1'b1;
        end
    end

    // With zero wait states DONE is entered straight from IDLE, so the
    // transfer must use the live decode instead of the captured copy.
    assign txIdx   = (state == IDLE) ? idxIn     : idxL;
    assign txWrite = (state == IDLE) ? bus.write : writeL;
    assign txData  = (state == IDLE) ? bus.wData : wDataL;
    assign txMask  = (state == IDLE) ? maskIn    : maskL;
    assign txErr   = (state == IDLE) ? errIn     : errL;

    // Transfer FSM next-state logic; an access phase without a setup
    // (enable already high in IDLE) is ignored.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        latch     = 1'b0;
        enterDone = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.sel && !bus.enable) begin
                    latch   = 1'b1;
                    cntNext = WaitLoad;
                    if (WaitStates == 0) begin
                        stateNext = DONE;
                        enterDone = 1'b1;
                    end else begin
                        stateNext = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!bus.sel) begin
                    stateNext = IDLE;
                    cntNext   = '0;
                end else if (cnt <= 4'd1) begin
                    stateNext = DONE;
                    cntNext   = '0;
                    enterDone = 1'b1;
                end else begin
                    cntNext = cnt - 4'd1;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State and wait counter registers.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // Capture of the setup phase so the requester may change the bus later.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            idxL   <= '0;
            writeL <= 1'b0;
            wDataL <= '0;
            maskL  <= '0;
            errL   <= 1'b0;
        end else if (latch) begin
            idxL   <= idxIn;
            writeL <= bus.write;
            wDataL <= bus.wData;
            maskL  <= maskIn;
            errL   <= errIn;
        end
    end

    assign bankWrEn = enterDone && txWrite && !txErr;

    apb_reg_bank #(
        .DataWidth (DataWidth),
        .RegNum    (RegNum),
        .IdxW      (IdxW)
    ) u_bank (
        .clk    (clk),
        .nReset (nReset),
        .wrEn   (bankWrEn),
        .wrIdx  (txIdx),
        .wrMask (txMask),
        .wrData (txData),
        .rdIdx  (txIdx),
        .rdData (bankRData)
    );

    // Response registers: a one-cycle pulse on the edge entering DONE;
    // rData carries read data only in that cycle and is zero on errors.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            readyQ    <= 1'b0;
            subErrorQ <= 1'b0;
            rDataQ    <= '0;
        end else begin
            readyQ    <= enterDone;
            subErrorQ <= enterDone && txErr;
            rDataQ    <= (enterDone && !txWrite && !txErr) ? bankRData : '0;
        end
    end

    assign bus.ready    = readyQ;
    assign bus.subError = subErrorQ;
    assign bus.rData    = rDataQ;

endmodule
